rcpu_irq_ctrl: RTL and testbench

- Interrupt controller directly upstream of the rcpu core.
- Collects NSRC edge-triggered interrupt sources, applies a software mask and picks the highest-priority pending source.
- Drives the core's irq, intAddr and intData inputs and consumes its turnOffIRQ acknowledge.
- Mask and pending registers are memory-mapped on the core's data bus.

---
 rtl/rcpu_irq_ctrl_if.sv | 50 +++++
 rtl/rcpu_irq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_rcpu_irq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rcpu_irq_ctrl_if.sv
// rcpu_irq_ctrl_if
// -----------------------------------------------------------------------------
// Bundles the interrupt handshake and the memory-mapped register bus that sit
// between the rcpu core and its interrupt controller.
//
// Parameters:
//   N  address bus width
//   M  data bus width
//
// Signals:
//   irq         controller -> core  interrupt request
//   turnOffIRQ  core -> controller  interrupt acknowledge
//   intAddr     controller -> core  vector address of the selected source
//   intData     controller -> core  ID of the selected source
//   memAddr     core -> controller  bus address
//   memWrite    core -> controller  bus write data
//   memWE       core -> controller  bus write enable
//   memRE       core -> controller  bus read enable
//   regHit      controller -> core  address selects a mapped register
//   regRead     controller -> core  mapped register read data
//
// Modports:
//   master  core side
//   slave   interrupt controller side
// -----------------------------------------------------------------------------
interface rcpu_irq_ctrl_if #(
  parameter int N = 32,
  parameter int M = 16
);
  logic         irq;
  logic         turnOffIRQ;
  logic [N-1:0] intAddr;
  logic [M-1:0] intData;
  logic [N-1:0] memAddr;
  logic [M-1:0] memWrite;
  logic         memWE;
  logic         memRE;
  logic         regHit;
  logic [M-1:0] regRead;

  modport master (
    input  irq, intAddr, intData, regHit, regRead,
    output turnOffIRQ, memAddr, memWrite, memWE, memRE
  );

  modport slave (
    output irq, intAddr, intData, regHit, regRead,
    input  turnOffIRQ, memAddr, memWrite, memWE, memRE
  );
endinterface

// File: rtl/rcpu_irq_ctrl.sv
// rcpu_irq_ctrl
// -----------------------------------------------------------------------------
// Interrupt controller directly upstream of the rcpu core. Collects NSRC
// rising-edge-triggered sources into PENDING, qualifies them with MASK, and
// presents the lowest-index eligible source to the core as irq/intAddr/intData
// until the core acknowledges with turnOffIRQ.
//
// Optional feature (macro RCPU_IRQ_SYNC_EN): when defined, every src bit goes
// through a 2-flop synchronizer before edge detection (adds 2 cycles of
// src-to-PENDING latency, allows asynchronous sources).
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   src   NSRC interrupt source lines, rising-edge triggered
//   bus   rcpu_irq_ctrl_if.slave: irq handshake and register bus
//
// Register map (word addresses):
//   REG_BASE+0  MASK     R/W  bit=1 enables the source
//   REG_BASE+1  PENDING  R/W1C
//   REG_BASE+2  STATUS   R    {id[7:4], 0, state[2:1], irq[0]}
// -----------------------------------------------------------------------------
module rcpu_irq_ctrl #(
  parameter int           NSRC       = 8,
  parameter int           N          = 32,
  parameter int           M          = 16,
  parameter logic [N-1:0] VEC_BASE   = 32'h00000100,
  parameter int           VEC_STRIDE = 4,
  parameter logic [N-1:0] REG_BASE   = 32'hFFFF1080
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  rcpu_irq_ctrl_if.slave  bus
);

  localparam logic [N-1:0] ADDR_MASK    = REG_BASE;
  localparam logic [N-1:0] ADDR_PENDING = REG_BASE + N'(32'd1);
  localparam logic [N-1:0] ADDR_STATUS  = REG_BASE + N'(32'd2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_r, stateNext_s;
  logic [3:0]      id_r, idNext_s;
  logic            irq_r, irqNext_s;
  logic [N-1:0]    intAddr_r, intAddrNext_s;
  logic [M-1:0]    intData_r, intDataNext_s;

  logic [NSRC-1:0] srcIn_s;
  logic [NSRC-1:0] prev_r;
  logic [NSRC-1:0] rise_s;
  logic [NSRC-1:0] mask_r, maskNext_s;
  logic [NSRC-1:0] pending_r, pendingNext_s;
  logic [NSRC-1:0] pendClr_s;
  logic [NSRC-1:0] eligible_s;
  logic [3:0]      winId_s;
  logic [N-1:0]    vecAddr_s;
  logic            ackClr_s;

  logic            hitMask_s, hitPending_s, hitStatus_s;
  logic [7:0]      status_s;
  logic [M-1:0]    regRead_s;

`ifdef RCPU_IRQ_SYNC_EN
  logic [NSRC-1:0] srcMeta_r, srcSync_r;

  // Two-flop synchronizer for asynchronous interrupt sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srcMeta_r <= {NSRC{1'b0}};
      srcSync_r <= {NSRC{1'b0}};
    end else begin
      srcMeta_r <= src;
      srcSync_r <= srcMeta_r;
    end
  end

  assign srcIn_s = srcSync_r;
`else
  assign srcIn_s = src;
`endif

  // Edge-history flops: one-cycle delayed copy of the source lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r <= {NSRC{1'b0}};
    end else begin
      prev_r <= srcIn_s;
    end
  end

  assign rise_s     = srcIn_s & ~prev_r;
  assign eligible_s = pending_r & mask_r;

  // Lowest eligible index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    winId_s = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      winId_s = eligible_s[i] ? 4'(i) : winId_s;
    end
  end

  assign vecAddr_s = VEC_BASE + (N'(winId_s) * N'(VEC_STRIDE));

  // Register address decode.
  assign hitMask_s    = (bus.memAddr == ADDR_MASK);
  assign hitPending_s = (bus.memAddr == ADDR_PENDING);
  assign hitStatus_s  = (bus.memAddr == ADDR_STATUS);
  assign status_s     = {id_r, 1'b0, state_r, irq_r};

  // Combinational read mux; unused bits read as zero.
  always_comb begin
    regRead_s = {M{1'b0}};
    if (hitMask_s) begin
      regRead_s = M'(mask_r);
    end else if (hitPending_s) begin
      regRead_s = M'(pending_r);
    end else if (hitStatus_s) begin
      regRead_s = M'(status_s);
    end else begin
      regRead_s = {M{1'b0}};
    end
  end

  assign bus.regHit  = hitMask_s | hitPending_s | hitStatus_s;
  assign bus.regRead = regRead_s;

  // MASK and PENDING next-state: a new rising edge beats any same-cycle clear.
  always_comb begin
    maskNext_s = mask_r;
    pendClr_s  = {NSRC{1'b0}};
    ackClr_s   = 1'b0;
    if (bus.memWE && hitMask_s) begin
      maskNext_s = bus.memWrite[NSRC-1:0];
    end else begin
      maskNext_s = mask_r;
    end
    if (bus.memWE && hitPending_s) begin
      pendClr_s = bus.memWrite[NSRC-1:0];
    end else begin
      pendClr_s = {NSRC{1'b0}};
    end
    if ((state_r == REQ) && bus.turnOffIRQ) begin
      ackClr_s  = 1'b1;
      pendClr_s = pendClr_s | (NSRC'(32'd1) << id_r);
    end else begin
      ackClr_s  = 1'b0;
    end
    pendingNext_s = (pending_r & ~pendClr_s) | rise_s;
  end

  // MASK / PENDING registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r    <= {NSRC{1'b0}};
      pending_r <= {NSRC{1'b0}};
    end else begin
      mask_r    <= maskNext_s;
      pending_r <= pendingNext_s;
    end
  end

  // Request FSM next-state and output logic; outputs hold by default.
  always_comb begin
    stateNext_s   = state_r;
    idNext_s      = id_r;
    irqNext_s     = irq_r;
    intAddrNext_s = intAddr_r;
    intDataNext_s = intData_r;
    case (state_r)
      IDLE: begin
        if (eligible_s != {NSRC{1'b0}}) begin
          stateNext_s   = REQ;
          idNext_s      = winId_s;
          irqNext_s     = 1'b1;
          intAddrNext_s = vecAddr_s;
          intDataNext_s = M'(winId_s);
        end else begin
          stateNext_s   = IDLE;
        end
      end
      REQ: begin
        // Request is held until acked, regardless of mask/pending changes.
        if (ackClr_s) begin
          stateNext_s = ACK;
          irqNext_s   = 1'b0;
        end else begin
          stateNext_s = REQ;
        end
      end
      ACK: begin
        // One forced idle cycle keeps irq low between requests.
        stateNext_s = IDLE;
        irqNext_s   = 1'b0;
      end
      default: begin
        stateNext_s = IDLE;
        irqNext_s   = 1'b0;
      end
    endcase
  end

  // Request FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      id_r      <= 4'd0;
      irq_r     <= 1'b0;
      intAddr_r <= {N{1'b0}};
      intData_r <= {M{1'b0}};
    end else begin
      state_r   <= stateNext_s;
      id_r      <= idNext_s;
      irq_r     <= irqNext_s;
      intAddr_r <= intAddrNext_s;
      intData_r <= intDataNext_s;
    end
  end

  assign bus.irq     = irq_r;
  assign bus.intAddr = intAddr_r;
  assign bus.intData = intData_r;

  // memRE only qualifies reads in the integrating mux outside this block.
  logic unused_s;
  assign unused_s = ^{1'b0, bus.memRE, bus.memWrite};

endmodule

// File: tb/tb_rcpu_irq_ctrl.sv
// tb_rcpu_irq_ctrl
// -----------------------------------------------------------------------------
// Directed self-checking bench for rcpu_irq_ctrl with hand-computed values.
// -----------------------------------------------------------------------------
module tb_rcpu_irq_ctrl;

  localparam logic [31:0] A_MASK = 32'hFFFF1080;
  localparam logic [31:0] A_PEND = 32'hFFFF1081;
  localparam logic [31:0] A_STAT = 32'hFFFF1082;

`ifdef RCPU_IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] src;
  int         checkCount;
  int         passCount;

  rcpu_irq_ctrl_if #(.N(32), .M(16)) bus ();

  rcpu_irq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic regWrite(input logic [31:0] addr, input logic [15:0] data);
    bus.memAddr  = addr;
    bus.memWrite = data;
    bus.memWE    = 1'b1;
    tick(1);
    bus.memWE    = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.memAddr = addr;
    #1;
    checkVal(tag, 32'(bus.regRead), exp);
  endtask

  task automatic checkReq(input string tag, input logic [31:0] addr, input logic [31:0] id);
    checkVal({tag, "_irq"}, 32'(bus.irq), 32'd1);
    checkVal({tag, "_addr"}, bus.intAddr, addr);
    checkVal({tag, "_data"}, 32'(bus.intData), id);
  endtask

  // Acknowledge, then step through ACK back to IDLE.
  task automatic ackAndIdle(input string tag);
    bus.turnOffIRQ = 1'b1;
    tick(1);
    bus.turnOffIRQ = 1'b0;
    checkVal({tag, "_ackirq"}, 32'(bus.irq), 32'd0);
    tick(1);
    checkVal({tag, "_idleirq"}, 32'(bus.irq), 32'd0);
  endtask

  initial begin
    checkCount     = 0;
    passCount      = 0;
    rst            = 1'b0;
    src            = 8'h00;
    bus.turnOffIRQ = 1'b0;
    bus.memAddr    = 32'h0;
    bus.memWrite   = 16'h0;
    bus.memWE      = 1'b0;
    bus.memRE      = 1'b0;
    tick(2);
    checkVal("rst_irq", 32'(bus.irq), 32'd0);
    checkVal("rst_addr", bus.intAddr, 32'h0);
    checkVal("rst_data", 32'(bus.intData), 32'h0);
    rst = 1'b1;
    tick(1);
    readCheck("rst_mask", A_MASK, 32'h0);
    checkVal("hit_mask", 32'(bus.regHit), 32'd1);
    readCheck("miss_read", 32'hFFFF1083, 32'h0);
    checkVal("miss_hit", 32'(bus.regHit), 32'd0);

    // 1: single source, basic request/ack
    regWrite(A_MASK, 16'h0005);
    src = 8'h04;
    tick(1 + SYNC);
    src = 8'h00;
    readCheck("t1_pend", A_PEND, 32'h0004);
    checkVal("t1_irq_early", 32'(bus.irq), 32'd0);
    tick(1);
    checkReq("t1", 32'h00000108, 32'h2);
    readCheck("t1_stat_req", A_STAT, 32'h23);
    bus.turnOffIRQ = 1'b1;
    tick(1);
    bus.turnOffIRQ = 1'b0;
    checkVal("t1_ack_irq", 32'(bus.irq), 32'd0);
    readCheck("t1_pend_clr", A_PEND, 32'h0);
    readCheck("t1_stat_ack", A_STAT, 32'h24);
    tick(1);
    checkVal("t1_idle_irq", 32'(bus.irq), 32'd0);
    readCheck("t1_stat_idle", A_STAT, 32'h20);
    checkVal("t1_hold_addr", bus.intAddr, 32'h00000108);

    // 2: simultaneous sources, lowest index first
    regWrite(A_MASK, 16'h0003);
    src = 8'h03;
    tick(1 + SYNC);
    src = 8'h00;
    readCheck("t2_pend", A_PEND, 32'h0003);
    tick(1);
    checkReq("t2_first", 32'h00000100, 32'h0);
    ackAndIdle("t2_a");
    readCheck("t2_pend2", A_PEND, 32'h0002);
    tick(1);
    checkReq("t2_second", 32'h00000104, 32'h1);
    ackAndIdle("t2_b");

    // 3: higher-priority arrival does not preempt latched id
    regWrite(A_MASK, 16'h0009);
    src = 8'h08;
    tick(1 + SYNC);
    src = 8'h00;
    tick(1);
    checkReq("t3_req3", 32'h0000010C, 32'h3);
    src = 8'h01;
    tick(1 + SYNC);
    src = 8'h00;
    readCheck("t3_pend", A_PEND, 32'h0009);
    tick(2);
    checkReq("t3_hold", 32'h0000010C, 32'h3);
    ackAndIdle("t3_a");
    tick(1);
    checkReq("t3_req0", 32'h00000100, 32'h0);
    ackAndIdle("t3_b");

    // 4: masked pending, unmask, W1C during REQ
    regWrite(A_MASK, 16'h0000);
    src = 8'h10;
    tick(1 + SYNC);
    src = 8'h00;
    tick(2);
    readCheck("t4_pend", A_PEND, 32'h0010);
    checkVal("t4_masked_irq", 32'(bus.irq), 32'd0);
    regWrite(A_MASK, 16'h0010);
    checkVal("t4_prewrite_irq", 32'(bus.irq), 32'd0);
    tick(1);
    checkReq("t4_req", 32'h00000110, 32'h4);
    regWrite(A_PEND, 16'h0010);
    readCheck("t4_w1c", A_PEND, 32'h0);
    tick(2);
    checkReq("t4_held", 32'h00000110, 32'h4);
    ackAndIdle("t4");
    tick(2);
    checkVal("t4_no_rereq", 32'(bus.irq), 32'd0);

    // 5: rising edge beats same-cycle W1C
    regWrite(A_MASK, 16'h0000);
    src = 8'h20;
    if (SYNC > 0) tick(SYNC);
    regWrite(A_PEND, 16'h0020);
    src = 8'h00;
    readCheck("t5_setwins", A_PEND, 32'h0020);
    regWrite(A_PEND, 16'h0020);
    readCheck("t5_w1c", A_PEND, 32'h0);

    // 5b: rising edge beats same-cycle ACK clear, source re-requested
    regWrite(A_MASK, 16'h0002);
    src = 8'h02;
    tick(1 + SYNC);
    src = 8'h00;
    tick(1);
    checkReq("t5b_req", 32'h00000104, 32'h1);
    src = 8'h02;
    if (SYNC > 0) tick(SYNC);
    bus.turnOffIRQ = 1'b1;
    tick(1);
    bus.turnOffIRQ = 1'b0;
    src = 8'h00;
    readCheck("t5b_pend", A_PEND, 32'h0002);
    tick(2);
    checkReq("t5b_rereq", 32'h00000104, 32'h1);
    ackAndIdle("t5b");

    // 6: asynchronous reset mid-REQ
    regWrite(A_MASK, 16'h0008);
    src = 8'h08;
    tick(1 + SYNC);
    src = 8'h00;
    tick(1);
    checkReq("t6_req", 32'h0000010C, 32'h3);
    #3;
    rst = 1'b0;
    #1;
    checkVal("t6_irq", 32'(bus.irq), 32'd0);
    checkVal("t6_addr", bus.intAddr, 32'h0);
    checkVal("t6_data", 32'(bus.intData), 32'h0);
    tick(1);
    rst = 1'b1;
    readCheck("t6_stat", A_STAT, 32'h0);
    readCheck("t6_mask", A_MASK, 32'h0);
    readCheck("t6_pend", A_PEND, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
